hough_accum_vote: RTL and testbench
===================================

# hough_accum_vote

Accumulator stage of the Hough transform, directly downstream of the per-theta rho calculator. Consumes the stream of (rho row, theta) votes, increments the matching bin in an on-chip THETAS×RHOS accumulator with a read-modify-write pipeline at one vote per cycle, then scans the array and streams out every bin whose count meets a threshold. The same scan also clears the array for the next frame.

## Interface
Parameters:
- THETAS, 180, number of theta bins
- RHOS, 1024, number of rho bins (already offset so row index is non-negative)
- COUNT_WIDTH, 16, bits per accumulator bin
- Derived (localparam): RHO_W = $clog2(RHOS), THETA_W = $clog2(THETAS), ADDR_W = $clog2(THETAS*RHOS)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- vote_valid  in  1  vote present
- vote_ready  out  1  block accepts vote this cycle
- vote_rho  in  RHO_W  rho row index
- vote_theta  in  THETA_W  theta index
- frame_done  in  1  pulse: no more votes this frame
- threshold  in  COUNT_WIDTH  minimum count to report; sampled on entry to SCAN
- rd_valid  out  1  reported bin present
- rd_ready  in  1  consumer accepts bin
- rd_rho, rd_theta, rd_count  out  RHO_W/THETA_W/COUNT_WIDTH  reported bin
- scan_done  out  1  one-cycle pulse after last bin scanned

## Operation
- Address = vote_theta*RHOS + vote_rho; bin memory is RAM with 1-cycle read latency, read-first.
- States: CLEAR → VOTE → DRAIN → SCAN_RD ↔ SCAN_CHK ↔ EMIT → VOTE.
- CLEAR (entered on reset only): write 0 to addresses 0..THETAS*RHOS-1, one per cycle; vote_ready=0; after last address → VOTE.
- VOTE: vote_ready=1. Accepted vote (valid&ready) enters a 3-stage pipe: S0 address, S1 RAM read, S2 increment+write. Count saturates at 2^COUNT_WIDTH-1. Vote with rho≥RHOS or theta≥THETAS is accepted and discarded.
- Hazards: every vote's read value must include all earlier accepted votes; S1 forwards from S2 write and from the write of the previous cycle when addresses match. Back-to-back votes to one bin yield exact counts.
- frame_done in VOTE → DRAIN (a vote on the same cycle is accepted). frame_done in other states ignored.
- DRAIN: vote_ready=0 until pipe empty (3 cycles), then sample threshold, scan address 0 → SCAN_RD.
- SCAN_RD: issue read. SCAN_CHK: data valid; write 0 to same address; if count ≥ threshold and count ≠ 0 → EMIT, else advance.
- EMIT: hold rd_* stable with rd_valid=1 until rd_ready; then advance.
- Advance: if address is last → pulse scan_done, → VOTE; else address+1 → SCAN_RD.
- Scan order: theta-major, rho ascending within theta.

## Timing
- Reset values: vote_ready=0, rd_valid=0, rd_rho/rd_theta/rd_count=0, scan_done=0, state=CLEAR.
- Reset mid-operation: pipe flushed, in-flight votes lost, full CLEAR restarts.
- Vote accepted in cycle t → bin written at edge ending cycle t+2; visible to any vote accepted at t+1 onward.
- CLEAR duration THETAS*RHOS cycles; vote_ready rises cycle after final clear write.
- Scan: 2 cycles per bin not reported; reported bin 2 cycles + wait for rd_ready.
- rd_* change only after a handshake or on entry to EMIT; never drop rd_valid without rd_ready.
- scan_done high exactly one cycle, coincident with transition into VOTE; vote_ready=1 the next cycle.

## Structure
- Package hough_pkg: THETAS, RHOS, COUNT_WIDTH defaults, state enum type, vote struct {rho, theta}.
- Sub-module accum_ram: single-clock simple dual-port RAM, depth THETAS*RHOS, width COUNT_WIDTH, registered read, read-first; inferable as block RAM.
- Top holds FSM, vote pipe with forwarding, scan counter, output register.

## Test plan
- Reset → CLEAR lasts THETAS*RHOS cycles (small params THETAS=4, RHOS=8: 32 cycles) → vote_ready rises cycle 33.
- 5 back-to-back votes (rho=3, theta=1), frame_done, threshold=1 → single output rho=3 theta=1 count=5, then scan_done.
- Interleaved votes A,B,A,B,A (distinct bins), threshold=3 → only A reported, count=3; B (count 2) suppressed.
- COUNT_WIDTH=4, 20 votes to one bin → count=15 (saturated).
- Vote rho=8 (out of range) plus one valid vote, threshold=1 → only valid bin reported; second frame with no votes → zero rd_valid beats (array cleared).
- rd_ready held low 10 cycles during EMIT → rd_* stable, no bin lost; reset asserted mid-SCAN → outputs to reset values, CLEAR restarts.

Source files
------------

// File: rtl/hough_pkg.sv
// Shared types and default sizing for the Hough accumulator stage.
package hough_pkg;

  localparam int unsigned THETAS_DEF      = 180;
  localparam int unsigned RHOS_DEF        = 1024;
  localparam int unsigned COUNT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    StClear,
    StVote,
    StDrain,
    StScanRd,
    StScanChk,
    StEmit
  } state_e;

  typedef struct packed {
    logic [$clog2(RHOS_DEF)-1:0]   rho;
    logic [$clog2(THETAS_DEF)-1:0] theta;
  } vote_t;

endpackage

// File: rtl/hough_accum_vote_if.sv
// Vote input stream and reported-bin output stream of the Hough accumulator.
interface hough_accum_vote_if
  import hough_pkg::*;
#(
  parameter int unsigned THETAS      = THETAS_DEF,
  parameter int unsigned RHOS        = RHOS_DEF,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
);
  localparam int unsigned RHO_W   = $clog2(RHOS);
  localparam int unsigned THETA_W = $clog2(THETAS);

  logic                   vote_valid;
  logic                   vote_ready;
  logic [RHO_W-1:0]       vote_rho;
  logic [THETA_W-1:0]     vote_theta;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [RHO_W-1:0]       rd_rho;
  logic [THETA_W-1:0]     rd_theta;
  logic [COUNT_WIDTH-1:0] rd_count;

  modport master (
    output vote_valid, vote_rho, vote_theta, rd_ready,
    input  vote_ready, rd_valid, rd_rho, rd_theta, rd_count
  );

  modport slave (
    input  vote_valid, vote_rho, vote_theta, rd_ready,
    output vote_ready, rd_valid, rd_rho, rd_theta, rd_count
  );

endinterface

// File: rtl/accum_ram.sv
// Simple dual-port bin memory: one write port, one registered read port, read-first.
module accum_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hough_accum_vote.sv
// Hough accumulator: counts votes into a THETAS x RHOS bin array through a forwarding RMW
// pipe, then scans out bins meeting the threshold while clearing them for the next frame.
module hough_accum_vote
  import hough_pkg::*;
#(
  parameter int unsigned THETAS      = THETAS_DEF,
  parameter int unsigned RHOS        = RHOS_DEF,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  hough_accum_vote_if.slave      bus,
  input  logic                   frame_done,
  input  logic [COUNT_WIDTH-1:0] threshold,
  output logic                   scan_done
);
  localparam int unsigned RHO_W   = $clog2(RHOS);
  localparam int unsigned THETA_W = $clog2(THETAS);
  localparam int unsigned BINS    = THETAS * RHOS;
  localparam int unsigned ADDR_W  = $clog2(BINS);
  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  state_e                 state_q;
  logic [ADDR_W-1:0]      scan_addr_q;
  logic [RHO_W-1:0]       scan_rho_q;
  logic [THETA_W-1:0]     scan_theta_q;
  logic [1:0]             drain_cnt_q;
  logic [COUNT_WIDTH-1:0] thr_q;
  logic                   rd_valid_q;
  logic [RHO_W-1:0]       rd_rho_q;
  logic [THETA_W-1:0]     rd_theta_q;
  logic [COUNT_WIDTH-1:0] rd_count_q;

  logic                   s1_valid_q, s2_valid_q, wp_valid_q;
  logic [ADDR_W-1:0]      s1_addr_q, s2_addr_q, wp_addr_q;
  logic [COUNT_WIDTH-1:0] s2_count_q, wp_count_q;

  logic                   vote_fire, in_range, last_addr, hit, advance;
  logic [ADDR_W-1:0]      vote_addr;
  logic [COUNT_WIDTH-1:0] base, s1_count;
  logic                   ram_we;
  logic [ADDR_W-1:0]      ram_waddr, ram_raddr;
  logic [COUNT_WIDTH-1:0] ram_wdata, ram_rdata;

  assign bus.vote_ready = (state_q == StVote);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_rho     = rd_rho_q;
  assign bus.rd_theta   = rd_theta_q;
  assign bus.rd_count   = rd_count_q;

  assign vote_fire = bus.vote_valid && (state_q == StVote);
  assign in_range  = (32'(bus.vote_rho) < RHOS) && (32'(bus.vote_theta) < THETAS);
  assign vote_addr = ADDR_W'(32'(bus.vote_theta) * RHOS + 32'(bus.vote_rho));
  assign last_addr = (scan_addr_q == ADDR_W'(BINS - 1));
  assign hit       = (ram_rdata >= thr_q) && (ram_rdata != '0);

  // S2 holds the newest write to this bin, the last-cycle write register the one before it.
  always_comb begin
    base = ram_rdata;
    if (wp_valid_q && (wp_addr_q == s1_addr_q)) base = wp_count_q;
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) base = s2_count_q;
    s1_count = (base == CountMax) ? base : base + COUNT_WIDTH'(1);
  end

  always_comb begin
    ram_we    = s2_valid_q;
    ram_waddr = s2_addr_q;
    ram_wdata = s2_count_q;
    if ((state_q == StClear) || (state_q == StScanChk)) begin
      ram_we    = 1'b1;
      ram_waddr = scan_addr_q;
      ram_wdata = '0;
    end
    ram_raddr = (state_q == StVote) ? vote_addr : scan_addr_q;
  end

  always_comb begin
    advance = 1'b0;
    if ((state_q == StScanChk) && !hit) advance = 1'b1;
    if ((state_q == StEmit) && bus.rd_ready) advance = 1'b1;
    scan_done = advance && last_addr;
  end

  accum_ram #(
    .DEPTH (BINS),
    .WIDTH (COUNT_WIDTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_count_q <= '0;
      wp_valid_q <= 1'b0;
      wp_addr_q  <= '0;
      wp_count_q <= '0;
    end else begin
      s1_valid_q <= vote_fire && in_range;
      s1_addr_q  <= vote_addr;
      s2_valid_q <= s1_valid_q;
      s2_addr_q  <= s1_addr_q;
      s2_count_q <= s1_count;
      wp_valid_q <= s2_valid_q;
      wp_addr_q  <= s2_addr_q;
      wp_count_q <= s2_count_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StClear;
      scan_addr_q  <= '0;
      scan_rho_q   <= '0;
      scan_theta_q <= '0;
      drain_cnt_q  <= '0;
      thr_q        <= '0;
      rd_valid_q   <= 1'b0;
      rd_rho_q     <= '0;
      rd_theta_q   <= '0;
      rd_count_q   <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (last_addr) begin
            scan_addr_q <= '0;
            state_q     <= StVote;
          end else begin
            scan_addr_q <= scan_addr_q + ADDR_W'(1);
          end
        end
        StVote: begin
          if (frame_done) begin
            drain_cnt_q <= '0;
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          if (drain_cnt_q == 2'd2) begin
            thr_q        <= threshold;
            scan_addr_q  <= '0;
            scan_rho_q   <= '0;
            scan_theta_q <= '0;
            state_q      <= StScanRd;
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        StScanRd: state_q <= StScanChk;
        StScanChk: begin
          if (hit) begin
            rd_valid_q <= 1'b1;
            rd_rho_q   <= scan_rho_q;
            rd_theta_q <= scan_theta_q;
            rd_count_q <= ram_rdata;
            state_q    <= StEmit;
          end
        end
        StEmit: begin
          if (bus.rd_ready) rd_valid_q <= 1'b0;
        end
        default: state_q <= StClear;
      endcase

      if (advance) begin
        if (last_addr) begin
          state_q <= StVote;
        end else begin
          scan_addr_q <= scan_addr_q + ADDR_W'(1);
          if (scan_rho_q == RHO_W'(RHOS - 1)) begin
            scan_rho_q   <= '0;
            scan_theta_q <= scan_theta_q + THETA_W'(1);
          end else begin
            scan_rho_q <= scan_rho_q + RHO_W'(1);
          end
          state_q <= StScanRd;
        end
      end
    end
  end

endmodule

// File: tb/tb_hough_accum_vote.sv
// Randomised scoreboard bench for hough_accum_vote with a small non-power-of-two bin array.
module tb_hough_accum_vote;
  localparam int unsigned TH      = 3;
  localparam int unsigned RH      = 6;
  localparam int unsigned CW      = 4;
  localparam int unsigned RHO_W   = $clog2(RH);
  localparam int unsigned THETA_W = $clog2(TH);
  localparam int          BINS    = TH * RH;
  localparam int          CMAX    = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          frame_done;
  logic [CW-1:0] threshold;
  logic          scan_done;

  hough_accum_vote_if #(.THETAS(TH), .RHOS(RH), .COUNT_WIDTH(CW)) bus ();

  hough_accum_vote #(
    .THETAS     (TH),
    .RHOS       (RH),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .frame_done(frame_done),
    .threshold (threshold),
    .scan_done (scan_done)
  );

  typedef struct {
    int rho;
    int theta;
    int cnt;
    bit done;
  } exp_t;

  exp_t sb[$];
  int   model [TH][RH];
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   ready_mode = 1;
  int   stall_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_vote(input int rho, input int theta);
    if (rho < RH && theta < TH)
      model[theta][rho] = (model[theta][rho] < CMAX) ? model[theta][rho] + 1 : CMAX;
  endtask

  task automatic model_clear();
    for (int t = 0; t < TH; t++)
      for (int r = 0; r < RH; r++) model[t][r] = 0;
  endtask

  // Expected report list for the frame: theta-major, rho ascending, then the scan_done marker.
  task automatic push_expect(input int thr);
    for (int t = 0; t < TH; t++)
      for (int r = 0; r < RH; r++)
        if (model[t][r] != 0 && model[t][r] >= thr)
          sb.push_back('{rho: r, theta: t, cnt: model[t][r], done: 1'b0});
    sb.push_back('{rho: 0, theta: 0, cnt: 0, done: 1'b1});
    model_clear();
  endtask

  task automatic send_vote(input int rho, input int theta);
    int n = 0;
    @(negedge clock);
    bus.vote_valid = 1'b1;
    bus.vote_rho   = RHO_W'(rho);
    bus.vote_theta = THETA_W'(theta);
    while (!bus.vote_ready && n < 4000) begin
      @(negedge clock);
      n++;
    end
    chk("vote_accept", bus.vote_ready, 1);
    if (bus.vote_ready) model_vote(rho, theta);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.vote_valid = 1'b0;
  endtask

  task automatic issue_frame(input int thr, input bit with_vote, input int rho, input int theta);
    int n = 0;
    @(negedge clock);
    bus.vote_valid = 1'b0;
    while (!bus.vote_ready && n < 4000) begin
      @(negedge clock);
      n++;
    end
    chk("frame_ready", bus.vote_ready, 1);
    bus.vote_valid = with_vote;
    bus.vote_rho   = RHO_W'(rho);
    bus.vote_theta = THETA_W'(theta);
    frame_done     = 1'b1;
    threshold      = CW'(thr);
    if (with_vote) model_vote(rho, theta);
    push_expect(thr);
    @(negedge clock);
    bus.vote_valid = 1'b0;
    frame_done     = 1'b0;
  endtask

  task automatic frame(input int thr, input bit with_vote, input int rho, input int theta);
    int s = done_cnt;
    int n = 0;
    issue_frame(thr, with_vote, rho, theta);
    while (done_cnt == s && n < 4000) begin
      @(negedge clock);
      n++;
    end
    chk("scan_done_seen", done_cnt - s, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_vote_ready", bus.vote_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_rho", bus.rd_rho, 0);
    chk("rst_rd_theta", bus.rd_theta, 0);
    chk("rst_rd_count", bus.rd_count, 0);
    chk("rst_scan_done", scan_done, 0);
  endtask

  task automatic clear_check();
    int c = 0;
    @(negedge clock);
    reset = 1'b1;
    do begin
      @(negedge clock);
      c++;
    end while (!bus.vote_ready && c < 200);
    chk("clear_cycles", c, BINS);
  endtask

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: bus.rd_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (bus.rd_valid && stall_cnt < 10) begin
          bus.rd_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.rd_ready = 1'b1;
        end
      end
      3: bus.rd_ready = 1'b0;
      default: bus.rd_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake and on every scan_done pulse.
  bit               stalled = 1'b0;
  bit               done_prev = 1'b0;
  logic [RHO_W-1:0]   h_rho;
  logic [THETA_W-1:0] h_theta;
  logic [CW-1:0]      h_count;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      stalled   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", bus.rd_valid, 1);
        chk("hold_rho", bus.rd_rho, h_rho);
        chk("hold_theta", bus.rd_theta, h_theta);
        chk("hold_count", bus.rd_count, h_count);
      end
      if (done_prev) begin
        chk("done_pulse_width", scan_done, 0);
        chk("ready_after_done", bus.vote_ready, 1);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        chk("rd_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rd_not_done_marker", e.done, 0);
          chk("rd_rho", bus.rd_rho, e.rho);
          chk("rd_theta", bus.rd_theta, e.theta);
          chk("rd_count", bus.rd_count, e.cnt);
        end
      end
      done_prev = 1'b0;
      if (scan_done) begin
        chk("done_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("done_order", e.done, 1);
        end
        chk("done_vote_ready_low", bus.vote_ready, 0);
        done_cnt++;
        done_prev = 1'b1;
      end
      stalled = bus.rd_valid && !bus.rd_ready;
      h_rho   = bus.rd_rho;
      h_theta = bus.rd_theta;
      h_count = bus.rd_count;
    end
  end

  initial begin
    int n;
    reset          = 1'b0;
    frame_done     = 1'b0;
    threshold      = '0;
    bus.vote_valid = 1'b0;
    bus.vote_rho   = '0;
    bus.vote_theta = '0;
    bus.rd_ready   = 1'b0;
    model_clear();
    repeat (3) @(negedge clock);
    check_reset_outputs();
    clear_check();

    repeat (5) send_vote(3, 1);
    frame(1, 1'b0, 0, 0);

    for (int i = 0; i < 5; i++) send_vote((i % 2) ? 5 : 2, (i % 2) ? 2 : 0);
    frame(3, 1'b0, 0, 0);

    repeat (20) send_vote(1, 1);
    frame(1, 1'b0, 0, 0);

    send_vote(6, 0);
    send_vote(4, 2);
    send_vote(2, 3);
    frame(1, 1'b0, 0, 0);
    frame(0, 1'b0, 0, 0);

    ready_mode = 2;
    stall_cnt  = 0;
    send_vote(0, 0);
    send_vote(5, 1);
    idle();
    send_vote(5, 1);
    frame(1, 1'b1, 2, 2);

    ready_mode = 0;
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(10, 40);
      for (int v = 0; v < n; v++) begin
        if ($urandom_range(0, 4) == 0) idle();
        send_vote($urandom_range(0, 7), $urandom_range(0, 3));
      end
      frame($urandom_range(1, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
            $urandom_range(0, 2));
    end

    ready_mode = 3;
    for (int i = 0; i < 10; i++) send_vote(i % RH, i % TH);
    issue_frame(1, 1'b0, 0, 0);
    n = 0;
    while (!bus.rd_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("emit_before_reset", bus.rd_valid, 1);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    sb.delete();
    model_clear();
    repeat (2) @(negedge clock);
    ready_mode = 0;
    clear_check();
    send_vote(0, 0);
    frame(1, 1'b0, 0, 0);

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
